// File: rtl/binary2excess3_multi.sv
// Sequential binary-to-BCD/excess-3 converter: one double-dabble iteration per clock,
// with a valid/ready handshake on both the input and the output.
module binary2excess3_multi #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   code_out,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned AccW = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [AccW-1:0]   code_q, code_d;

  logic [AccW-1:0]   acc_adj;
  logic [AccW-1:0]   acc_shift;
  logic [AccW-1:0]   code_fin;

  // Datapath for one iteration, plus the final result in the captured output code.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[AccW-2:0], sr_q[WIDTH-1]};
    code_fin  = acc_shift;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (mode_q) begin
        code_fin[4*i +: 4] = acc_shift[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sr_d    = bin_in;
          mode_d  = mode;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d = acc_shift;
        sr_d  = sr_q << 1;
        cnt_d = cnt_q + CntW'(1);
        // This edge performs the last iteration, so the result is final now.
        if (cnt_q == CntW'(WIDTH - 1)) begin
          code_d  = code_fin;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      code_q  <= code_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StShift);
  assign out_valid = (state_q == StDone);
  assign code_out  = code_q;

endmodule

// File: tb/tb_binary2excess3_multi.sv
// Directed and exhaustive checks of binary2excess3_multi with WIDTH=8, DIGITS=3.
module tb_binary2excess3_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin_in;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] code_out;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  binary2excess3_multi #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code_out  (code_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model(input int v, input logic m);
    logic [11:0] r;
    int          t;
    t = v;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(t % 10) + (m ? 4'd3 : 4'd0);
      t = t / 10;
    end
    return r;
  endfunction

  // Accept one value (caller is in IDLE, #1 after an edge or just after reset), wait for
  // out_valid, then release after `stall` cycles of out_ready=0.
  task automatic run_conv(input logic [7:0] b, input logic m, input int stall,
                          output logic [11:0] code, output int lat);
    in_valid = 1'b1;
    bin_in   = b;
    mode     = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin_in   = 8'($urandom);
    mode     = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    code = code_out;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [11:0] code;
    logic [11:0] held;
    int          lat;
    int          bad;

    rst       = 1'b1;
    in_valid  = 1'b0;
    bin_in    = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_code", 32'(code_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero in excess-3, accepted on the first edge after reset.
    in_valid = 1'b1;
    bin_in   = 8'd0;
    mode     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("zero_busy", 32'(busy), 32'd1);
    check("zero_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("zero_latency", 32'(lat), 32'd8);
    check("zero_code", 32'(code_out), 32'h333);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("zero_in_ready_after", 32'(in_ready), 32'd1);
    check("zero_out_valid_after", 32'(out_valid), 32'd0);
    check("zero_code_retained", 32'(code_out), 32'h333);

    run_conv(8'd255, 1'b0, 0, code, lat);
    check("255_bcd", 32'(code), 32'h255);
    check("255_bcd_latency", 32'(lat), 32'd8);
    run_conv(8'd255, 1'b1, 0, code, lat);
    check("255_ex3", 32'(code), 32'h588);

    // Input changes during SHIFT must be ignored.
    in_valid = 1'b1;
    bin_in   = 8'd9;
    mode     = 1'b1;
    @(posedge clk); #1;
    mode   = 1'b0;
    bin_in = 8'd200;
    repeat (3) begin
      @(posedge clk); #1;
    end
    lat = 3;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignore_latency", 32'(lat), 32'd8);
    check("ignore_code", 32'(code_out), 32'h33C);
    // in_valid still high in DONE: no effect.
    @(posedge clk); #1;
    check("ignore_done_hold", 32'(out_valid), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ignore_back_idle", 32'(in_ready), 32'd1);

    // Backpressure: hold DONE for 5 cycles.
    in_valid = 1'b1;
    bin_in   = 8'd73;
    mode     = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    held = code_out;
    check("bp_code", 32'(held), 32'h073);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (code_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("bp_stable_cycles_bad", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle", 32'(in_ready), 32'd1);
    check("bp_out_valid_low", 32'(out_valid), 32'd0);

    // Reset mid-SHIFT discards the conversion.
    in_valid = 1'b1;
    bin_in   = 8'd99;
    mode     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_code", 32'(code_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    check("midrst_no_result", 32'(bad), 32'd0);
    run_conv(8'd128, 1'b0, 0, code, lat);
    check("midrst_128", 32'(code), 32'h128);

    // Exhaustive sweep with random backpressure.
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        run_conv(8'(v), 1'(m), int'($urandom_range(0, 3)), code, lat);
        check($sformatf("sweep_m%0d_v%0d", m, v), {20'd0, code}, {20'd0, model(v, 1'(m))});
        if (lat != 8) check($sformatf("sweep_lat_m%0d_v%0d", m, v), 32'(lat), 32'd8);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
